// File: rtl/router_rx_port_if.sv
// rtl/router_rx_port_if.sv - word stream from one router input port to the crossbar
interface router_rx_port_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_dest;
  logic              out_last;

  modport master (output out_valid, out_data, out_dest, out_last, input  out_ready);
  modport slave  (input  out_valid, out_data, out_dest, out_last, output out_ready);
endinterface

// File: rtl/router_rx_port.sv
// rtl/router_rx_port.sv - serial router input port: address/pad/data deserialiser with valid/ready output
module router_rx_port #(
  parameter int NUM_PORTS  = 16,
  parameter int DATA_W     = 8,
  parameter int PAD_CYCLES = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             frame_n,
  input  logic             valid_n,
  input  logic             din,
  router_rx_port_if.master o_bus,
  output logic             busy,
  output logic             pkt_done,
  output logic             err_addr,
  output logic             err_trunc,
  output logic             err_ovf
);
  localparam int ADDR_W  = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_MAX = (ADDR_W > PAD_CYCLES) ? ADDR_W : PAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PAD, S_DATA, S_DROP} state_t;

  state_t            r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_shift;
  logic [BIT_W-1:0]  r_bitcnt;
  logic              r_out_valid, r_out_last;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_dest;
  logic              r_pkt_done, r_err_addr, r_err_trunc, r_err_ovf;

  logic              w_addr_done, w_err_addr, w_take_bit, w_pkt_end;
  logic              w_word_done, w_trunc, w_can_load, w_bad_addr;
  logic [ADDR_W-1:0] w_addr_bits;
  logic [DATA_W-1:0] w_shift_bits;

  // Address and word bits are ORed in LSB first; both registers start cleared.
  assign w_addr_bits  = (r_state == S_IDLE) ? ADDR_W'(din) : (r_addr | (ADDR_W'(din) << r_cnt));
  assign w_shift_bits = r_shift | (DATA_W'(din) << r_bitcnt);
  assign w_bad_addr   = {1'b0, r_addr} >= (ADDR_W+1)'(NUM_PORTS);
  assign w_word_done  = w_take_bit && (r_bitcnt == BIT_W'(DATA_W - 1));
  assign w_trunc      = w_pkt_end && (w_take_bit ? !w_word_done : (r_bitcnt != '0));
  assign w_can_load   = !r_out_valid || o_bus.out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_addr_done  = 1'b0;
    w_err_addr   = 1'b0;
    w_take_bit   = 1'b0;
    w_pkt_end    = 1'b0;
    case (r_state)
      S_IDLE: if (!frame_n) begin
        w_next_state = (ADDR_W == 1) ? S_PAD : S_ADDR;
        w_addr_done  = (ADDR_W == 1);
      end
      S_ADDR: if (frame_n) begin
        w_err_addr   = 1'b1;
        w_next_state = S_IDLE;
      end else if (r_cnt == CNT_W'(ADDR_W - 1)) begin
        w_addr_done  = 1'b1;
        w_next_state = S_PAD;
      end
      S_PAD: if (frame_n) begin
        w_err_addr   = 1'b1;
        w_next_state = S_IDLE;
      end else if (r_cnt == CNT_W'(PAD_CYCLES - 1)) begin
        w_err_addr   = w_bad_addr;
        w_next_state = w_bad_addr ? S_DROP : S_DATA;
      end
      S_DATA: begin
        w_take_bit = !valid_n;
        if (frame_n) begin
          w_pkt_end    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_DROP: if (frame_n) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_dest  <= '0;
      r_pkt_done  <= 1'b0;
      r_err_addr  <= 1'b0;
      r_err_trunc <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      if (r_state == S_IDLE)
        r_cnt <= (ADDR_W == 1) ? '0 : CNT_W'(1);
      else if (w_next_state != r_state)
        r_cnt <= '0;
      else if (r_state == S_ADDR || r_state == S_PAD)
        r_cnt <= r_cnt + 1'b1;

      if (!frame_n && (r_state == S_IDLE || r_state == S_ADDR))
        r_addr <= w_addr_bits;

      if (r_state != S_DATA || w_pkt_end || w_word_done) begin
        r_shift  <= '0;
        r_bitcnt <= '0;
      end else if (w_take_bit) begin
        r_shift  <= w_shift_bits;
        r_bitcnt <= r_bitcnt + 1'b1;
      end

      // A completing word may overwrite the held one only when that one leaves this cycle.
      if (w_word_done && w_can_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_shift_bits;
        r_out_last  <= frame_n;
        r_out_dest  <= r_addr;
      end else if (r_out_valid && o_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_addr_done && !r_out_valid)
        r_out_dest <= w_addr_bits;

      r_pkt_done  <= w_pkt_end;
      r_err_addr  <= w_err_addr;
      r_err_trunc <= w_trunc;
      r_err_ovf   <= w_word_done && !w_can_load;
    end
  end

  assign o_bus.out_valid = r_out_valid;
  assign o_bus.out_data  = r_out_data;
  assign o_bus.out_dest  = r_out_dest;
  assign o_bus.out_last  = r_out_last;
  assign busy            = (r_state != S_IDLE) | r_out_valid;
  assign pkt_done        = r_pkt_done;
  assign err_addr        = r_err_addr;
  assign err_trunc       = r_err_trunc;
  assign err_ovf         = r_err_ovf;
endmodule

// File: tb/tb_router_rx_port.sv
// tb/tb_router_rx_port.sv - bench for router_rx_port: 16-port and 12-port instances on a shared serial line
module tb_router_rx_port;
  logic clock, reset_n, frame_n, valid_n, din, out_ready;

  router_rx_port_if #(.DATA_W(8), .ADDR_W(4)) bus0 ();
  router_rx_port_if #(.DATA_W(8), .ADDR_W(4)) bus1 ();

  logic       o_valid [2], o_last [2], o_busy [2], o_done [2];
  logic       o_eaddr [2], o_etrunc [2], o_eovf [2];
  logic [7:0] o_data [2];
  logic [3:0] o_dest [2];

  router_rx_port #(.NUM_PORTS(16)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .frame_n(frame_n), .valid_n(valid_n), .din(din),
    .o_bus(bus0), .busy(o_busy[0]), .pkt_done(o_done[0]), .err_addr(o_eaddr[0]),
    .err_trunc(o_etrunc[0]), .err_ovf(o_eovf[0]));

  router_rx_port #(.NUM_PORTS(12)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .frame_n(frame_n), .valid_n(valid_n), .din(din),
    .o_bus(bus1), .busy(o_busy[1]), .pkt_done(o_done[1]), .err_addr(o_eaddr[1]),
    .err_trunc(o_etrunc[1]), .err_ovf(o_eovf[1]));

  assign bus0.out_ready = out_ready;
  assign bus1.out_ready = out_ready;
  assign o_valid[0] = bus0.out_valid;  assign o_valid[1] = bus1.out_valid;
  assign o_data[0]  = bus0.out_data;   assign o_data[1]  = bus1.out_data;
  assign o_dest[0]  = bus0.out_dest;   assign o_dest[1]  = bus1.out_dest;
  assign o_last[0]  = bus0.out_last;   assign o_last[1]  = bus1.out_last;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: what each instance should show after the next clock edge.
  int         np [2] = '{16, 12};
  logic       m_valid [2], m_last [2], m_done [2], m_eaddr [2], m_etrunc [2], m_eovf [2];
  logic [7:0] m_data [2];
  logic [3:0] m_dest [2];
  logic       m_active;

  // Events the driver announces for the cycle it is about to drive.
  logic       ev_word [2], ev_pend [2], ev_trunc [2], ev_eaddr [2];
  logic [7:0] ev_val;
  logic       ev_last, ev_active;
  logic [3:0] cur_dest;

  logic [7:0] pw [0:15];
  int         rdy_mode;
  logic [7:0] obs [2][$];
  int         ovf_seen;

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  task automatic clear_events();
    for (int k = 0; k < 2; k++) begin
      ev_word[k] = 0; ev_pend[k] = 0; ev_trunc[k] = 0; ev_eaddr[k] = 0;
    end
    ev_val = '0; ev_last = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_last[k] = 0; m_done[k] = 0; m_eaddr[k] = 0;
      m_etrunc[k] = 0; m_eovf[k] = 0; m_data[k] = '0; m_dest[k] = '0;
    end
    m_active = 0; ev_active = 0;
    clear_events();
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s_valid%0d", tag, k), o_valid[k], 0);
      check_eq($sformatf("%s_data%0d", tag, k), o_data[k], 0);
      check_eq($sformatf("%s_dest%0d", tag, k), o_dest[k], 0);
      check_eq($sformatf("%s_last%0d", tag, k), o_last[k], 0);
      check_eq($sformatf("%s_busy%0d", tag, k), o_busy[k], 0);
      check_eq($sformatf("%s_flags%0d", tag, k),
               {o_done[k], o_eaddr[k], o_etrunc[k], o_eovf[k]}, 0);
    end
  endtask

  task automatic step(input logic fr, input logic vn, input logic d);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("valid%0d", k), o_valid[k], m_valid[k]);
      if (m_valid[k]) begin
        check_eq($sformatf("data%0d", k), o_data[k], m_data[k]);
        check_eq($sformatf("dest%0d", k), o_dest[k], m_dest[k]);
        check_eq($sformatf("last%0d", k), o_last[k], m_last[k]);
      end
      check_eq($sformatf("busy%0d", k), o_busy[k], m_active | m_valid[k]);
      check_eq($sformatf("pkt_done%0d", k), o_done[k], m_done[k]);
      check_eq($sformatf("err_addr%0d", k), o_eaddr[k], m_eaddr[k]);
      check_eq($sformatf("err_trunc%0d", k), o_etrunc[k], m_etrunc[k]);
      check_eq($sformatf("err_ovf%0d", k), o_eovf[k], m_eovf[k]);
    end
    if (o_eovf[0]) ovf_seen++;
    frame_n = fr; valid_n = vn; din = d;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = rb();
    endcase
    for (int k = 0; k < 2; k++)
      if (o_valid[k] && out_ready) obs[k].push_back(o_data[k]);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = ev_pend[k]; m_eaddr[k] = ev_eaddr[k]; m_etrunc[k] = ev_trunc[k]; m_eovf[k] = 0;
      if (ev_word[k]) begin
        if (!m_valid[k] || out_ready) begin
          m_valid[k] = 1; m_data[k] = ev_val; m_last[k] = ev_last; m_dest[k] = cur_dest;
        end else begin
          m_eovf[k] = 1;
        end
      end else if (m_valid[k] && out_ready) begin
        m_valid[k] = 0;
      end
    end
    m_active = ev_active;
    clear_events();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      ev_active = 0;
      step(1'b1, 1'b1, rb());
    end
  endtask

  // abort_at 1..3: frame_n rises in that address cycle; 4..8: in pad cycle abort_at-4.
  task automatic send_packet(input int dest, input int nbits, input int abort_at, input int stall_pct,
                             input int fixed_stall_bit, input bit end_on_stall, input int reset_at_bit);
    logic bad [2];
    logic [31:0] dv;
    logic lastb;
    int   ns;
    dv = dest;
    cur_dest = dv[3:0];
    for (int k = 0; k < 2; k++) bad[k] = (dest >= np[k]);
    for (int i = 0; i < 4; i++) begin
      if (abort_at == i && i > 0) begin
        ev_eaddr[0] = 1; ev_eaddr[1] = 1; ev_active = 0;
        step(1'b1, 1'b1, rb());
        return;
      end
      ev_active = 1;
      step(1'b0, 1'b1, dv[i]);
    end
    for (int i = 0; i < 5; i++) begin
      if (abort_at == 4 + i) begin
        ev_eaddr[0] = 1; ev_eaddr[1] = 1; ev_active = 0;
        step(1'b1, rb(), rb());
        return;
      end
      if (i == 4) for (int k = 0; k < 2; k++) ev_eaddr[k] = bad[k];
      ev_active = 1;
      step(1'b0, rb(), rb());
    end
    for (int b = 0; b < nbits; b++) begin
      if (b == reset_at_bit) begin
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1; frame_n = 1'b1; valid_n = 1'b1;
        return;
      end
      ns = (b == fixed_stall_bit) ? 4 : (($urandom_range(99) < stall_pct) ? $urandom_range(1, 3) : 0);
      repeat (ns) begin
        ev_active = 1;
        step(1'b0, 1'b1, rb());
      end
      lastb = (b == nbits - 1) && !end_on_stall;
      for (int k = 0; k < 2; k++) if (!bad[k]) begin
        ev_word[k] = (b % 8 == 7);
        if (lastb) begin ev_pend[k] = 1; ev_trunc[k] = (nbits % 8 != 0); end
      end
      ev_val = pw[b / 8]; ev_last = lastb; ev_active = !lastb;
      step(lastb, 1'b0, pw[b / 8][b % 8]);
    end
    if (nbits == 0 || end_on_stall) begin
      for (int k = 0; k < 2; k++) if (!bad[k]) begin
        ev_pend[k] = 1; ev_trunc[k] = (nbits % 8 != 0);
      end
      ev_active = 0;
      step(1'b1, 1'b1, rb());
    end
  endtask

  task automatic check_obs(input string tag, input int k, input int exp_n, input logic [31:0] w0,
                           input logic [31:0] w1);
    check_eq($sformatf("%s_count%0d", tag, k), obs[k].size(), exp_n);
    if (exp_n > 0 && obs[k].size() > 0) check_eq($sformatf("%s_w0_%0d", tag, k), obs[k][0], w0);
    if (exp_n > 1 && obs[k].size() > 1) check_eq($sformatf("%s_w1_%0d", tag, k), obs[k][1], w1);
  endtask

  task automatic clear_obs();
    obs[0].delete(); obs[1].delete(); ovf_seen = 0;
  endtask

  initial begin
    reset_n = 1'b0; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0; out_ready = 1'b1;
    rdy_mode = 0;
    model_reset();
    for (int i = 0; i < 16; i++) pw[i] = '0;
    @(negedge clock);
    check_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    clear_obs();
    pw[0] = 8'hA5; pw[1] = 8'h3C;
    send_packet(3, 16, -1, 0, -1, 0, -1);
    idle(3);
    check_obs("two_words", 0, 2, 8'hA5, 8'h3C);
    check_obs("two_words", 1, 2, 8'hA5, 8'h3C);

    clear_obs();
    pw[0] = 8'h11; pw[1] = 8'h22;
    send_packet(13, 16, -1, 0, -1, 0, -1);
    idle(3);
    check_obs("bad_addr", 0, 2, 8'h11, 8'h22);
    check_obs("bad_addr", 1, 0, 0, 0);

    clear_obs();
    pw[0] = 8'hFF; pw[1] = 8'h05;
    send_packet(2, 11, -1, 0, -1, 0, -1);
    idle(3);
    check_obs("trunc", 0, 1, 8'hFF, 0);

    clear_obs();
    rdy_mode = 1;
    pw[0] = 8'h01; pw[1] = 8'h02; pw[2] = 8'h03;
    send_packet(4, 24, -1, 0, -1, 0, -1);
    idle(2);
    rdy_mode = 0;
    idle(4);
    check_obs("backpressure", 0, 1, 8'h01, 0);
    check_eq("backpressure_ovf_pulses", ovf_seen, 2);

    clear_obs();
    pw[0] = 8'h5A;
    send_packet(9, 8, -1, 0, 4, 0, -1);
    idle(3);
    check_obs("stall", 0, 1, 8'h5A, 0);

    rdy_mode = 1;
    pw[0] = 8'h77; pw[1] = 8'h88; pw[2] = 8'h99;
    send_packet(5, 20, -1, 0, -1, 0, 12);
    rdy_mode = 0;
    clear_obs();
    pw[0] = 8'hC3;
    send_packet(7, 8, -1, 0, -1, 0, -1);
    idle(3);
    check_obs("after_reset", 0, 1, 8'hC3, 0);

    rdy_mode = 2;
    for (int p = 0; p < 80; p++) begin
      int abort_at;
      for (int i = 0; i < 16; i++) pw[i] = 8'($urandom);
      abort_at = ($urandom_range(9) == 0) ? $urandom_range(1, 8) : -1;
      send_packet($urandom_range(15), $urandom_range(40), abort_at, 20, -1, ($urandom_range(3) == 0), -1);
      idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/router_rx_port.md
Name: router_rx_port

Overview:
- Parametrised serial input-port receiver for the router; one instance per input port in an N-port router.
- Deserialises the router's serial packet protocol (frame_n / valid_n / din) into a destination address plus DATA_W-bit words.
- Words are presented on a valid/ready interface to the downstream crossbar/FIFO.
- Generalises the fixed 16-port, 8-bit, 5-pad format to configurable port count, word width and pad length, and adds error reporting and backpressure.

Parameters:
- NUM_PORTS, 16, number of router output ports; ADDR_W = max(1, clog2(NUM_PORTS)) is a derived localparam.
- DATA_W, 8, bits per output word.
- PAD_CYCLES, 5, pad cycles between address and data (≥1).

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- frame_n  input  1  low for the duration of a packet; goes high on the last data bit
- valid_n  input  1  low when din carries a data bit (DATA phase only)
- din  input  1  serial data, LSB first
- out_valid  output  1  out_data/out_dest/out_last valid
- out_ready  input  1  downstream accepts the word when out_valid && out_ready
- out_data  output  DATA_W  assembled word
- out_dest  output  ADDR_W  destination port of the current packet
- out_last  output  1  word is the final word of the packet
- busy  output  1  port is occupied
- pkt_done  output  1  one-cycle pulse at packet end
- err_addr  output  1  one-cycle pulse: address ≥ NUM_PORTS, or frame_n rose during ADDR/PAD
- err_trunc  output  1  one-cycle pulse: packet ended with a partial word
- err_ovf  output  1  one-cycle pulse: completed word dropped because of backpressure

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low (reset_n).
- Reset values: state = IDLE; all counters 0; out_valid, out_last, busy, pkt_done and all err_* = 0; out_data and out_dest = 0.
- Reset mid-packet aborts immediately. No output pulses are generated, and the pending word is discarded.
- All inputs are sampled on the rising clock edge.
- States: IDLE, ADDR, PAD, DATA, DROP.
- IDLE:
  - frame_n=0 captures din as address bit 0.
  - If ADDR_W=1, go to PAD; otherwise go to ADDR with the bit count at 1.
- ADDR:
  - Each cycle shifts din into address bit[cnt], LSB first.
  - After ADDR_W bits total, go to PAD and latch out_dest.
  - If frame_n=1 in ADDR: pulse err_addr and return to IDLE.
- PAD:
  - Count PAD_CYCLES cycles; din and valid_n are ignored.
  - When the count completes: if address ≥ NUM_PORTS, pulse err_addr and go to DROP; otherwise go to DATA.
  - If frame_n=1 in PAD: pulse err_addr and return to IDLE.
- DATA:
  - A cycle with valid_n=0 shifts din into word bit[bitcnt]; bitcnt wraps at DATA_W.
  - A cycle with valid_n=1 is a stall; the shift register is unchanged.
  - When the DATA_W-th bit is taken, the word is complete. It is registered to out_data, and out_valid is asserted the next cycle (latency 1 from the last bit).
  - out_last=1 if frame_n=1 on that bit's cycle.
- Packet end in DATA: any cycle with frame_n=1.
  - Return to IDLE next cycle and pulse pkt_done in that same next cycle.
  - If bitcnt≠0 after the shift, the partial word is discarded and err_trunc pulses (with pkt_done).
  - Empty packet (no data bits): pkt_done only, no word, no error.
- DROP: consume cycles until frame_n=1, then return to IDLE. No words and no pkt_done.
- Output handshake:
  - out_valid holds, with stable out_data/out_dest/out_last, until out_valid && out_ready.
  - If a new word completes while out_valid=1 and out_ready=0, the new word is dropped and err_ovf pulses; the held word is unchanged.
  - A dropped final word means no out_last; pkt_done still pulses.
  - Acceptance and a new completion in the same cycle: the new word replaces the held word with no error.
- busy = (state≠IDLE) | out_valid.
- Back-to-back packets: frame_n=0 in the first IDLE cycle after a packet end starts a new packet (minimum 1 frame_n-high cycle between packets).

Test Plan:
- Defaults; dest=3, words 0xA5 then 0x3C, out_ready=1:
  - out_dest=3 on both words.
  - out_data 0xA5 (out_last=0) then 0x3C (out_last=1).
  - pkt_done one cycle after the final bit; no err_*.
- NUM_PORTS=12, dest=13 → err_addr pulse at the end of PAD, no out_valid, busy until frame_n rises, then IDLE.
- Defaults; frame_n rises after 11 data bits (0xFF then 3 bits) → 0xFF output with out_last=0; err_trunc and pkt_done pulse together.
- out_ready=0 throughout; 3-word packet 0x01,0x02,0x03 → out_data stays 0x01; err_ovf pulses twice; raising out_ready releases 0x01 only.
- valid_n stalls of 4 cycles inserted mid-word 0x5A → 0x5A assembled correctly, output one cycle after its 8th bit.
- reset_n low in mid-DATA → all outputs 0 immediately (asynchronous), no pkt_done; the next packet, dest=7 with word 0xC3, is received correctly.
